// File: rtl/divider_4bits.sv
`default_nettype none
// ============================================================================
// Module      : divider_4bits
// Description : Sequential 4-bit unsigned restoring divider. One quotient bit
//               is produced per RUN cycle, MSB first, so a normal division
//               completes four cycles after the request is accepted.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk    in   1  clock, all state updates on the rising edge
//   rst_n  in   1  synchronous active-low reset
//   start  in   1  request pulse, accepted in IDLE or DONE
//   a      in   4  dividend, captured on accept
//   b      in   4  divisor, captured on accept
//   busy   out  1  high while the division steps are running
//   done   out  1  one-cycle completion pulse, q/r/err valid
//   q      out  4  quotient, held until the next completion
//   r      out  4  remainder, held until the next completion
//   err    out  1  divide-by-zero flag, valid with done
// Configuration
//   DIV_ZERO_FLAG_EN : when defined, a zero divisor completes on the accept
//                      edge with q=4'hF, r=a, err=1. When undefined the zero
//                      divisor runs the full algorithm and err is tied low.
// ============================================================================
module divider_4bits (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       busy,
  output logic       done,
  output logic [3:0] q,
  output logic [3:0] r,
  output logic       err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_next;

  // r_dvd starts as the dividend; each step shifts its MSB into the partial
  // remainder and the new quotient bit into its LSB, so after four steps it
  // holds the quotient.
  logic [3:0] r_dvd;
  logic [3:0] r_dsr;
  logic [3:0] r_rem;
  logic [1:0] r_cnt;
  logic [3:0] r_q;
  logic [3:0] r_r;

  logic       w_accept;
  logic       w_zero_skip;
  logic       w_last;
  logic [4:0] w_shift;
  logic       w_qbit;
  logic [3:0] w_sub;
  logic [3:0] w_rem_next;

  // A new request is taken in IDLE, and also in DONE for back-to-back use.
  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last   = (r_cnt == 2'd3);

`ifdef DIV_ZERO_FLAG_EN
  assign w_zero_skip = (b == 4'd0);
`else
  assign w_zero_skip = 1'b0;
`endif

  // One restoring step on the 5-bit partial remainder. The 5-bit compare is
  // the borrow of the extended subtract; when it succeeds the difference is
  // below the divisor, so the low 4 bits of the subtract are exact.
  assign w_shift    = {r_rem, r_dvd[3]};
  assign w_qbit     = (w_shift >= {1'b0, r_dsr});
  assign w_sub      = w_shift[3:0] - r_dsr;
  assign w_rem_next = w_qbit ? w_sub : w_shift[3:0];

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_next = w_zero_skip ? S_DONE : S_RUN;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_next = S_DONE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Datapath. Operands are only captured on accept, so start or operand
  // changes during RUN cannot disturb a division in progress. Results are
  // written only on the edge that enters DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dvd <= 4'd0;
      r_dsr <= 4'd0;
      r_rem <= 4'd0;
      r_cnt <= 2'd0;
      r_q   <= 4'd0;
      r_r   <= 4'd0;
    end else if (w_accept) begin
      r_dvd <= a;
      r_dsr <= b;
      r_rem <= 4'd0;
      r_cnt <= 2'd0;
      if (w_zero_skip) begin
        r_q <= 4'hF;
        r_r <= a;
      end
    end else if (r_state == S_RUN) begin
      r_dvd <= {r_dvd[2:0], w_qbit};
      r_rem <= w_rem_next;
      r_cnt <= r_cnt + 2'd1;
      if (w_last) begin
        r_q <= {r_dvd[2:0], w_qbit};
        r_r <= w_rem_next;
      end
    end
  end

`ifdef DIV_ZERO_FLAG_EN
  logic r_err;

  // The flag only moves with a completion: set by a skipped zero-divisor
  // request, cleared by any division that finishes through RUN.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_accept && w_zero_skip) begin
      r_err <= 1'b1;
    end else if ((r_state == S_RUN) && w_last) begin
      r_err <= 1'b0;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
  assign q    = r_q;
  assign r    = r_r;

endmodule
`default_nettype wire

// File: doc/divider_4bits.md
DIVIDER_4BITS -- requirements
Module: divider_4bits

Interface
REQ-001 Parameters: none; operand width SHALL be fixed at 4 bits.
REQ-002 clk  input  1  sole clock; all state SHALL update on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request pulse; SHALL be sampled on rising edge of clk.
REQ-005 a  input  4  dividend, unsigned; SHALL be captured when start is accepted.
REQ-006 b  input  4  divisor, unsigned; SHALL be captured when start is accepted.
REQ-007 busy  output  1  high while a division is in progress.
REQ-008 done  output  1  one-cycle pulse; q, r and err are valid.
REQ-009 q  output  4  quotient, held until next completion.
REQ-010 r  output  4  remainder, held until next completion.
REQ-011 err  output  1  divide-by-zero flag, valid with done (see REQ-027).

Function
REQ-012 Algorithm SHALL be restoring division, one quotient bit per RUN cycle, MSB first, using a 5-bit partial remainder (borrow-extended subtract).
REQ-013 Per step: rem = {rem[3:0], next dividend bit}; if rem >= divisor then rem -= divisor and qbit=1, else qbit=0.
REQ-014 FSM states SHALL be IDLE, RUN and DONE.
REQ-015 IDLE: start=1 -> capture a and b, clear partial remainder, step counter=0, go to RUN; start=0 -> stay.
REQ-016 RUN: one step per cycle; after step with counter=3, load q and r and go to DONE; else increment counter.
REQ-017 DONE: done=1 for exactly one cycle; start=1 -> behave as IDLE accept (back-to-back); else go to IDLE.
REQ-018 Latency: start accepted at edge E -> done high during the cycle following edge E+4.
REQ-019 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE.
REQ-020 start while in RUN SHALL be ignored; captured operands and progress unchanged.
REQ-021 Input changes on a/b while busy SHALL NOT affect the result.
REQ-022 q and r SHALL change only on the edge entering DONE; stable at all other times.
REQ-023 Results SHALL satisfy a = q*b + r with r < b for every b != 0 (all 240 pairs).
REQ-024 b=0 via the normal algorithm SHALL yield q=4'hF, r=a.

Reset
REQ-025 rst_n=0 at a rising edge SHALL force state IDLE, busy=0, done=0, q=0, r=0, err=0, counter=0.
REQ-026 Reset SHALL take priority over start and over any in-progress division; the aborted operation SHALL produce no done pulse.

Configuration
REQ-027 Macro DIV_ZERO_FLAG_EN defined: b=0 on accept -> skip RUN, go to DONE on next edge with q=4'hF, r=a, err=1 (latency 1 cycle); err=0 on every other completion.
REQ-028 DIV_ZERO_FLAG_EN undefined: b=0 SHALL run the full 4-cycle algorithm per REQ-024; err SHALL be tied 0; port list unchanged.

Verification
REQ-029 a=13, b=4, start pulse -> busy for 4 cycles, done pulse, q=3, r=1, err=0.
REQ-030 a=15, b=1 -> q=15, r=0; a=3, b=7 -> q=0, r=3; exhaustive sweep of all b!=0 pairs checks REQ-023.
REQ-031 a=9, b=0 -> macro defined: done 1 cycle after accept, q=15, r=9, err=1; undefined: done after 4 RUN cycles, q=15, r=9, err=0.
REQ-032 a=13, b=4 started, then start with a=6, b=2 during RUN -> ignored; q=3, r=1.
REQ-033 rst_n=0 on second RUN cycle -> next cycle busy=0, done=0, q=0, r=0; no done pulse follows.
REQ-034 start held high continuously with a=8, b=3 -> done pulses every 5 cycles, each q=2, r=2.
